// File: rtl/comp_fifo_arbiter.sv
// Result-FIFO controller: round-robin write arbitration, fixed-latency reads, clear sequencing.
// Keeps its own occupancy count since the FIFO flags trail the FIFO contents.
module comp_fifo_arbiter #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int FCWIDTH = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0,
    input  logic [WIDTH-1:0]   data0,
    output logic               ack0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   data1,
    output logic               ack1,
    input  logic               rd_req,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_valid,
    input  logic               clr_req,
    output logic               clr_done,
    output logic [FCWIDTH:0]   count,
    output logic [WIDTH-1:0]   fifo_din,
    output logic               fifo_write,
    output logic               fifo_read,
    output logic               fifo_clr,
    input  logic               fifo_full,
    input  logic               fifo_empty,
    input  logic [WIDTH-1:0]   fifo_dout
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        CLEAR_WAIT
    } state_t;

    localparam logic [FCWIDTH:0] CNT_MAX = (FCWIDTH+1)'(DEPTH);
    localparam logic [FCWIDTH:0] CNT_ONE = (FCWIDTH+1)'(1);

    state_t state;
    logic   last_grant;
    logic   rd_stage;
    logic   elig0;
    logic   elig1;
    logic   idle_go;
    logic   grant;
    logic   gsel;
    logic   rd_ok;

    // An acked requester sits out one cycle so one request is never taken twice
    always_comb begin
        elig0   = req0 & ~ack0;
        elig1   = req1 & ~ack1;
        idle_go = (state == IDLE) & ~clr_req;
        grant   = idle_go & (elig0 | elig1) & (count < CNT_MAX) & ~fifo_full;
        gsel    = (elig0 & elig1) ? ~last_grant : elig1;
        rd_ok   = idle_go & rd_req & (count != '0) & ~fifo_empty;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rd_stage   <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            clr_done   <= 1'b0;
            count      <= '0;
            fifo_din   <= '0;
            fifo_write <= 1'b0;
            fifo_read  <= 1'b0;
            fifo_clr   <= 1'b0;
        end else begin
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            fifo_write <= 1'b0;
            fifo_read  <= 1'b0;
            fifo_clr   <= 1'b0;
            clr_done   <= 1'b0;
            // Read pipeline runs regardless of state so in-flight reads finish
            rd_stage   <= fifo_read;
            rd_valid   <= rd_stage;
            rd_data    <= rd_stage ? fifo_dout : '0;
            unique case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        fifo_clr <= 1'b1;
                    end else begin
                        if (grant) begin
                            ack0       <= ~gsel;
                            ack1       <= gsel;
                            fifo_write <= 1'b1;
                            fifo_din   <= gsel ? data1 : data0;
                            last_grant <= gsel;
                        end
                        if (rd_ok) begin
                            fifo_read <= 1'b1;
                        end
                        if (grant & ~rd_ok) begin
                            count <= count + CNT_ONE;
                        end else if (rd_ok & ~grant) begin
                            count <= count - CNT_ONE;
                        end
                    end
                end
                CLEAR: begin
                    state <= CLEAR_WAIT;
                    count <= '0;
                end
                CLEAR_WAIT: begin
                    state    <= IDLE;
                    clr_done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_fifo_arbiter.sv
// Bench for comp_fifo_arbiter: lagging-flag FIFO stand-in, transaction model,
// per-cycle comparison and directed scenarios with literal expectations.
module tb_comp_fifo_arbiter;

    localparam int W   = 32;
    localparam int D   = 4;
    localparam int FCW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req0 = 1'b0;
    logic           req1 = 1'b0;
    logic [W-1:0]   data0 = '0;
    logic [W-1:0]   data1 = '0;
    logic           rd_req = 1'b0;
    logic           clr_req = 1'b0;
    logic           ack0;
    logic           ack1;
    logic [W-1:0]   rd_data;
    logic           rd_valid;
    logic           clr_done;
    logic [FCW:0]   count;
    logic [W-1:0]   fifo_din;
    logic           fifo_write;
    logic           fifo_read;
    logic           fifo_clr;
    logic           fifo_full;
    logic           fifo_empty;
    logic [W-1:0]   fifo_dout;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    comp_fifo_arbiter #(.WIDTH(W), .DEPTH(D), .FCWIDTH(FCW)) dut (
        .clock(clk), .reset(rst_n),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .clr_req(clr_req), .clr_done(clr_done), .count(count),
        .fifo_din(fifo_din), .fifo_write(fifo_write),
        .fifo_read(fifo_read), .fifo_clr(fifo_clr),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // FIFO stand-in: flags reflect the contents as they were one cycle ago
    logic [W-1:0] fq[$];
    logic [W-1:0] ftmp;
    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            fq.delete();
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            fifo_dout  <= '0;
        end else begin
            fifo_empty <= (fq.size() == 0);
            fifo_full  <= (fq.size() >= D);
            if (fifo_clr) begin
                fq.delete();
                fifo_dout <= '0;
            end else begin
                ftmp = '0;
                if (fifo_read && fq.size() > 0) ftmp = fq.pop_front();
                fifo_dout <= ftmp;
                if (fifo_write) fq.push_back(fifo_din);
            end
        end
    end

    // Requesters: hold a word until acked, then present the next one
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    always begin
        @(posedge clk);
        #2;
        if (ack0 === 1'b1 && q0.size() > 0) q0.delete(0);
        if (ack1 === 1'b1 && q1.size() > 0) q1.delete(0);
        req0 = (q0.size() > 0);
        req1 = (q1.size() > 0);
        if (req0) data0 = q0[0];
        if (req1) data1 = q1[0];
    end

    task automatic push0(input logic [W-1:0] w);
        q0.push_back(w);
        req0 = 1'b1;
        data0 = q0[0];
    endtask

    task automatic push1(input logic [W-1:0] w);
        q1.push_back(w);
        req1 = 1'b1;
        data1 = q1[0];
    endtask

    // Transaction model: words in flight, delivery edge numbers, occupancy
    int           k;
    int           m_cnt;
    int           m_phase;
    int           m_fsize;
    int           pick;
    bit           m_last;
    bit           m_empty;
    bit           m_full;
    bit           n_empty;
    bit           n_full;
    bit           el0;
    bit           el1;
    bit           rok;
    bit           gnt;
    bit           o_wr;
    bit           o_rd;
    bit           o_clr;
    logic [W-1:0] m_words[$];
    logic [W-1:0] due[int];
    logic         e_ack0, e_ack1, e_wr, e_rd, e_clr, e_done, e_rv;
    logic [W-1:0] e_din, e_rdata;

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            k = 0; m_cnt = 0; m_phase = 0; m_fsize = 0;
            m_last = 1'b1; m_empty = 1'b1; m_full = 1'b0;
            m_words.delete();
            due.delete();
            e_ack0 = 0; e_ack1 = 0; e_wr = 0; e_rd = 0;
            e_clr = 0; e_done = 0; e_rv = 0;
            e_din = '0; e_rdata = '0;
        end else begin
            k++;
            o_wr = e_wr; o_rd = e_rd; o_clr = e_clr;
            n_empty = (m_fsize == 0);
            n_full = (m_fsize >= D);
            if (o_clr) m_fsize = 0;
            else begin
                if (o_rd && m_fsize > 0) m_fsize--;
                if (o_wr) m_fsize++;
            end
            el0 = req0 && !e_ack0;
            el1 = req1 && !e_ack1;
            e_ack0 = 0; e_ack1 = 0; e_wr = 0; e_rd = 0; e_clr = 0; e_done = 0;
            if (due.exists(k)) begin
                e_rv = 1; e_rdata = due[k]; due.delete(k);
            end else begin
                e_rv = 0; e_rdata = '0;
            end
            case (m_phase)
                0: begin
                    if (clr_req) begin
                        m_phase = 1; e_clr = 1;
                    end else begin
                        rok = rd_req && m_cnt > 0 && !m_empty;
                        gnt = (el0 || el1) && m_cnt < D && !m_full;
                        if (rok) begin
                            e_rd = 1;
                            due[k+2] = m_words.pop_front();
                            m_cnt--;
                        end
                        if (gnt) begin
                            if (el0 && el1) pick = m_last ? 0 : 1;
                            else pick = el1 ? 1 : 0;
                            if (pick == 1) e_ack1 = 1; else e_ack0 = 1;
                            e_wr = 1;
                            e_din = (pick == 1) ? data1 : data0;
                            m_last = (pick == 1);
                            m_words.push_back(e_din);
                            m_cnt++;
                        end
                    end
                end
                1: begin
                    m_phase = 2; m_cnt = 0; m_words.delete();
                end
                default: begin
                    m_phase = 0; e_done = 1;
                end
            endcase
            m_empty = n_empty;
            m_full = n_full;
        end
    end

    always begin
        @(negedge clk);
        chk("ack0", 32'(ack0), 32'(e_ack0));
        chk("ack1", 32'(ack1), 32'(e_ack1));
        chk("fifo_write", 32'(fifo_write), 32'(e_wr));
        chk("fifo_din", fifo_din, e_din);
        chk("fifo_read", 32'(fifo_read), 32'(e_rd));
        chk("fifo_clr", 32'(fifo_clr), 32'(e_clr));
        chk("clr_done", 32'(clr_done), 32'(e_done));
        chk("count", 32'(count), 32'(m_cnt));
        chk("rd_valid", 32'(rd_valid), 32'(e_rv));
        chk("rd_data", rd_data, e_rdata);
    end

    logic [W-1:0] got[$];
    always begin
        @(negedge clk);
        if (rd_valid === 1'b1) got.push_back(rd_data);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        q0.delete(); q1.delete();
        req0 = 0; req1 = 0; rd_req = 0; clr_req = 0;
        got.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    int seq[4];
    int exp_seq[4];
    int hit;

    initial begin
        exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_acks", 32'({ack0, ack1, fifo_write, fifo_read}), 0);
        chk("rst_misc", 32'({fifo_clr, clr_done, rd_valid}), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // single write right after reset
        push0(32'hA5A5A5A5);
        tick();
        chk("t1_ack0", 32'(ack0), 1);
        chk("t1_wr", 32'(fifo_write), 1);
        chk("t1_din", fifo_din, 32'hA5A5A5A5);
        chk("t1_count", 32'(count), 1);
        tick();
        chk("t1_ack0_off", 32'(ack0), 0);
        chk("t1_wr_off", 32'(fifo_write), 0);
        chk("t1_din_hold", fifo_din, 32'hA5A5A5A5);

        // alternating grants up to full occupancy
        do_reset();
        push0(32'h100); push0(32'h101);
        push1(32'h200); push1(32'h201); push1(32'h202);
        for (int i = 0; i < 4; i++) begin
            tick();
            seq[i] = ack1 ? 1 : (ack0 ? 0 : 9);
        end
        for (int i = 0; i < 4; i++) chk("t2_ack_order", 32'(seq[i]), 32'(exp_seq[i]));
        chk("t2_count4", 32'(count), 4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_no_ack", 32'({ack0, ack1}), 0);
        end
        chk("t2_count_hold", 32'(count), 4);

        // read and write on the same edge at full occupancy
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("t4_count3", 32'(count), 3);
        chk("t4_rd", 32'(fifo_read), 1);
        chk("t4_ack1_refused", 32'(ack1), 0);
        tick();
        chk("t4_rv_early", 32'(rd_valid), 0);
        tick();
        chk("t4_rv", 32'(rd_valid), 1);
        chk("t4_rdata", rd_data, 32'h100);
        hit = 0;
        for (int i = 0; i < 4 && hit == 0; i++) begin
            tick();
            if (ack1 === 1'b1) hit = 1;
        end
        chk("t4_ack1_late", 32'(hit), 1);
        chk("t4_count_back", 32'(count), 4);
        chk("t4_din", fifo_din, 32'h202);

        // three writes, four reads
        do_reset();
        push0(32'h11); push0(32'h22); push0(32'h33);
        for (int i = 0; i < 20 && m_cnt != 3; i++) tick();
        chk("t3_count3", 32'(count), 3);
        tick(3);
        rd_req = 1'b1;
        tick(4);
        rd_req = 1'b0;
        tick(4);
        chk("t3_nread", 32'(got.size()), 3);
        if (got.size() == 3) begin
            chk("t3_rd0", got[0], 32'h11);
            chk("t3_rd1", got[1], 32'h22);
            chk("t3_rd2", got[2], 32'h33);
        end
        chk("t3_count0", 32'(count), 0);

        // clear while occupied with a pending requester
        do_reset();
        push0(32'h51); push0(32'h52); push0(32'h53); push0(32'h54);
        for (int i = 0; i < 20 && m_cnt != 3; i++) tick();
        chk("t5_count3", 32'(count), 3);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("t5_clr", 32'(fifo_clr), 1);
        chk("t5_noack_a", 32'(ack0), 0);
        chk("t5_count_in_clr", 32'(count), 3);
        tick();
        chk("t5_clr_off", 32'(fifo_clr), 0);
        chk("t5_count0", 32'(count), 0);
        chk("t5_noack_b", 32'(ack0), 0);
        tick();
        chk("t5_done", 32'(clr_done), 1);
        chk("t5_noack_c", 32'(ack0), 0);
        tick();
        chk("t5_ack_resume", 32'(ack0), 1);
        chk("t5_din", fifo_din, 32'h54);
        chk("t5_count1", 32'(count), 1);
        chk("t5_done_off", 32'(clr_done), 0);

        // reset lands while a read is in flight
        tick(3);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("t6_rd", 32'(fifo_read), 1);
        #2;
        rst_n = 1'b0;
        got.delete();
        #1;
        chk("t6_rd_async", 32'(fifo_read), 0);
        chk("t6_count_async", 32'(count), 0);
        chk("t6_outs_async", 32'({ack0, ack1, fifo_write, rd_valid, clr_done}), 0);
        chk("t6_din_async", fifo_din, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick(5);
        chk("t6_no_rv", 32'(got.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/comp_fifo_arbiter.md
Name: comp_fifo_arbiter

Overview:
Controller for the shared comparator-test result FIFO (WIDTH x DEPTH, registered flags, registered read data that reads as zero when read is not asserted). It arbitrates two write requesters round-robin, for example the LCT peak-finder result path (requester 0) and the host/test-pattern path (requester 1). It also sequences host reads with fixed latency and runs FIFO clear. It keeps its own occupancy count because the FIFO flags lag the FIFO contents by one cycle.

Parameters:
WIDTH, 32, data word width
DEPTH, 4, FIFO depth in words
FCWIDTH, 2, FIFO pointer width (log2 DEPTH)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req0  input  1  requester 0 write request (level, held until ack0)
data0  input  WIDTH  requester 0 data, stable while req0 is high
ack0  output  1  one-cycle accept pulse to requester 0
req1  input  1  requester 1 write request
data1  input  WIDTH  requester 1 data
ack1  output  1  one-cycle accept pulse to requester 1
rd_req  input  1  host read request, one word per cycle it is high
rd_data  output  WIDTH  read word
rd_valid  output  1  rd_data valid strobe
clr_req  input  1  clear request (level or pulse)
clr_done  output  1  one-cycle pulse when the clear completes
count  output  FCWIDTH+1  controller occupancy, 0..DEPTH
fifo_din  output  WIDTH  to FIFO DIn
fifo_write  output  1  to FIFO Write
fifo_read  output  1  to FIFO Read
fifo_clr  output  1  to FIFO Clr
fifo_full  input  1  from FIFO Full
fifo_empty  input  1  from FIFO Empty
fifo_dout  input  WIDTH  from FIFO DOut

Behaviour:
- All outputs are registered. While reset=0, every output is 0, the state is IDLE, count=0, and last_grant=1, so requester 0 wins the first tie.
- States and transitions:
  - IDLE -> CLEAR when clr_req=1.
  - CLEAR -> CLEAR_WAIT unconditionally. fifo_clr=1 for exactly this cycle. count<=0. No grants and no reads in this state.
  - CLEAR_WAIT -> IDLE unconditionally. clr_done=1 for one cycle on entry to IDLE.
  - clr_req seen in IDLE has priority over any grant or read decided on the same edge.
- Write grant, evaluated in IDLE at each edge:
  - Requester i is eligible when req_i=1 and ack_i is currently 0. A requester is never accepted twice from one request.
  - A grant is allowed only if count<DEPTH and fifo_full=0.
  - If both requesters are eligible, grant the one not equal to last_grant. Otherwise grant the single eligible requester.
  - On a grant, in the next cycle: ack_i=1, fifo_write=1, fifo_din=data_i, last_grant<=i.
  - When no grant is made, fifo_write=0 and fifo_din holds its last value.
  - A single requester can be accepted at most every other cycle. Two alternating requesters can be accepted every cycle.
- Read, evaluated in IDLE at each edge:
  - Accept when rd_req=1, count>0 and fifo_empty=0. The next cycle has fifo_read=1.
  - fifo_empty gating blocks reads during the FIFO's one-cycle flag lag after the first write.
  - rd_valid=1 and rd_data=fifo_dout are registered two edges after the accepting edge.
  - A read that is in flight when a clear starts still completes and delivers valid data.
  - rd_req that is ignored while empty or during a clear is dropped, not queued.
- Count:
  - +1 on a grant.
  - -1 on a read accept.
  - Unchanged when a grant and a read accept occur on the same edge.
  - Never exceeds DEPTH and never wraps below 0.
- Simultaneous write and read at count=DEPTH: the write is refused and the read is accepted. The write can be granted on the next edge.

Test Plan:
1. Reset release, req0=1 with data0=0xA5A5A5A5 -> ack0 and fifo_write=1 for one cycle one edge later, fifo_din=0xA5A5A5A5, count=1.
2. req0 and req1 held high for 4 cycles -> acks alternate 0,1,0,1, count reaches 4, no further acks while count=4.
3. Write 0x11,0x22,0x33, then rd_req high for 4 cycles -> rd_valid 3 times with rd_data 0x11,0x22,0x33 at 2-edge latency, fourth request dropped, count=0.
4. count=4 with req1=1 and rd_req=1 on the same edge -> read accepted, write refused, count=3, ack1 one edge later, count back to 4.
5. clr_req while count=3 and req0 high -> fifo_clr one cycle, no ack during CLEAR/CLEAR_WAIT, clr_done after 2 edges, count=0, then ack0 resumes.
6. reset driven low mid-read with fifo_read=1 -> all outputs 0 immediately (asynchronously), no rd_valid after reset is released.
